native_bus_dma: RTL
===================

// Module: native_bus_dma
// PURPOSE
//  Bus initiator for the PicoRV32 native memory interface: copies LEN 32-bit words
//  from SRC to DST by issuing alternating read/write transactions.
//  Drives mem_valid/addr/wdata/wstrb and waits for mem_ready from responders on the
//  same bus, such as ioport instances and RAM. Sits beside the CPU behind a bus mux.
//  Command inputs come from a control-register block.
// PARAMETERS
//  LEN_W          16   width of word-count input len
//  TIMEOUT_CYCLES 256  cycles mem_valid may wait for mem_ready (only with DMA_TIMEOUT_EN)
// PORTS
//  clk        in   1      clock; all logic on posedge
//  resetn     in   1      reset: synchronous, active-low
//  start      in   1      command strobe; accepted only in IDLE
//  src_addr   in   32     source byte address; bits [1:0] forced to 0 on capture
//  dst_addr   in   32     destination byte address; bits [1:0] forced to 0 on capture
//  len        in   LEN_W  number of words to copy
//  busy       out  1      1 in every state except IDLE
//  done       out  1      1-cycle pulse at end of command (success, len=0 or timeout)
//  err        out  1      sticky timeout flag; cleared by next accepted start
//  mem_valid  out  1      transaction request
//  mem_addr   out  32     transaction address
//  mem_wdata  out  32     write data (read buffer)
//  mem_wstrb  out  4      4'h0 on reads, 4'hF on writes
//  mem_ready  in   1      responder acknowledge; may be combinational or registered
//  mem_rdata  in   32     read data; sampled on the cycle mem_ready=1 during a read
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, err=0, mem_valid=0, mem_addr=0, mem_wdata=0,
//   mem_wstrb=0; internal cnt/src/dst/buf=0. Reset during a transfer aborts it with
//   no resume and no done pulse.
//  FSM: IDLE -> RD -> RGAP -> WR -> WGAP -> (RD | FIN) ; FIN -> IDLE.
//  IDLE: on start=1, latch src/dst/len and clear err. If len==0, go to FIN;
//   otherwise go to RD. start outside IDLE is ignored with no side effect.
//  RD: mem_valid=1, mem_addr=src, mem_wstrb=0. On mem_ready=1, capture
//   mem_rdata->buf, clear mem_valid at the same edge, go to RGAP.
//  RGAP/WGAP: one cycle with mem_valid=0, mandatory. Registered-ready responders
//   need a valid-low cycle to reset their ready.
//  WR: mem_valid=1, mem_addr=dst, mem_wdata=buf, mem_wstrb=4'hF. On mem_ready=1,
//   clear mem_valid; src+=4, dst+=4, cnt-=1; go to WGAP.
//  WGAP: go to FIN if cnt==0, else to RD.
//  FIN: done=1 for exactly this cycle, busy=1; then IDLE.
//  mem_addr/wstrb/wdata stay stable while mem_valid=1. No signal changes before ready.
//  Address arithmetic is modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.
//  cnt is LEN_W wide; len=2^LEN_W-1 is legal.
//  Latency: start sampled at edge N gives mem_valid=1 from cycle N+1.
//   Zero-wait responder: 4 cycles/word + 1 FIN cycle.
//  mem_ready seen while mem_valid=0 is ignored.
// CONFIGURATION
//  DMA_TIMEOUT_EN defined: in RD/WR a counter increments each cycle with
//   mem_ready=0. When it reaches TIMEOUT_CYCLES: mem_valid->0, err->1, go to FIN
//   (done pulses). The counter clears on each transaction start.
//  DMA_TIMEOUT_EN undefined: wait for mem_ready indefinitely; err tied to 0.
// TESTING
//  T1 RAM model src=0x100 holds {0x11111111,0x22222222,0x33333333}, dst=0x200, len=3
//     -> 3 reads (wstrb 0), 3 writes (wstrb F) in alternation; dst words match;
//     one done pulse; busy low the cycle after done.
//  T2 len=0 -> done pulses 1 cycle after start; mem_valid never asserted.
//  T3 second start (src=0x900) mid-copy of T1 -> ignored; addresses continue
//     0x104/0x204...
//  T4 src=0xFFFF_FFFC, len=2 -> reads at 0xFFFF_FFFC then 0x0000_0000.
//  T5 responder never ready, DMA_TIMEOUT_EN, TIMEOUT_CYCLES=16 -> mem_valid drops
//     after 16 cycles, err=1, done pulse. Without the macro, mem_valid stays 1 for
//     1000 cycles.
//  T6 resetn=0 for 1 cycle during WR of word 2 -> all outputs at reset values next
//     cycle; no further bus activity.

Source files
------------

// File: rtl/native_bus_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : native_bus_dma_if
// Brief    : PicoRV32-style native memory bus between an initiator and responders.
// Revision : 1.0 - initial release
// ============================================================================
interface native_bus_dma_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/native_bus_dma.sv
`default_nettype none
// ============================================================================
// Module   : native_bus_dma
// Brief    : Word-copy DMA initiator on the native memory bus (read/write pairs).
//            Define DMA_TIMEOUT_EN to abort a transaction stuck without mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module native_bus_dma #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    native_bus_dma_if.master bus
);
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_RGAP = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_WGAP = 3'd4;
    localparam logic [2:0] c_FIN  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_buf;
    logic             w_in_txn;
    logic             w_timeout;

    assign w_in_txn = (r_state == c_RD) || (r_state == c_WR);

`ifdef DMA_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;

    // Fires on the last allowed waiting cycle so mem_valid is high for exactly TIMEOUT_CYCLES.
    assign w_timeout = w_in_txn && !bus.mem_ready &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn || !w_in_txn || bus.mem_ready) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end

        if (!resetn) begin
            r_err <= 1'b0;
        end else if (r_state == c_IDLE && start) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (start) w_next = (len == '0) ? c_FIN : c_RD;
            c_RD: begin
                if (w_timeout)          w_next = c_FIN;
                else if (bus.mem_ready) w_next = c_RGAP;
            end
            c_RGAP: w_next = c_WR;
            c_WR: begin
                if (w_timeout)          w_next = c_FIN;
                else if (bus.mem_ready) w_next = c_WGAP;
            end
            c_WGAP: w_next = (r_cnt == '0) ? c_FIN : c_RD;
            c_FIN:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_src <= '0;
            r_dst <= '0;
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_src <= {src_addr[31:2], 2'b00};
                        r_dst <= {dst_addr[31:2], 2'b00};
                        r_cnt <= len;
                    end
                end
                c_RD: if (bus.mem_ready) r_buf <= bus.mem_rdata;
                c_WR: begin
                    // Pointers advance only after the write completes, keeping mem_addr stable while valid.
                    if (bus.mem_ready) begin
                        r_src <= r_src + 32'd4;
                        r_dst <= r_dst + 32'd4;
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != c_IDLE);
    assign done          = (r_state == c_FIN);
    assign bus.mem_valid = w_in_txn;
    assign bus.mem_addr  = (r_state == c_WR) ? r_dst : r_src;
    assign bus.mem_wdata = r_buf;
    assign bus.mem_wstrb = (r_state == c_WR) ? 4'hF : 4'h0;
endmodule
`default_nettype wire
